// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Brief    : Shared types and code-word bit positions for the Hamming(7,4)
//            demo sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Sequencer states; every state between CAPTURE and CORRECT lasts one cycle
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        ENCODE  = 3'd2,
        INJECT  = 3'd3,
        DECODE  = 3'd4,
        CORRECT = 3'd5,
        SHOW    = 3'd6
    } state_t;

    // Bit index inside code[6:0]; code position k lives at bit k-1
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D1 = 2;
    localparam int POS_P3 = 3;
    localparam int POS_D2 = 4;
    localparam int POS_D3 = 5;
    localparam int POS_D4 = 6;

    // Pull the data bits back out of a code word as {d1,d2,d3,d4}
    function automatic logic [3:0] extract_data(input logic [6:0] code);
        return {code[POS_D1], code[POS_D2], code[POS_D3], code[POS_D4]};
    endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming74_core.sv
`default_nettype none
// ============================================================================
// Module   : hamming74_core
// Brief    : Combinational Hamming(7,4) encoder and syndrome generator.
// Revision : 1.0 - initial release
// ============================================================================
module hamming74_core
    import hamming_pkg::*;
(
    input  logic [3:0] i_data,   // {d1,d2,d3,d4}
    input  logic [6:0] i_code,   // bit[k] = position k+1
    output logic [6:0] o_code,
    output logic [2:0] o_syn     // {s3,s2,s1}
);

    // Place data bits and the three even-parity bits into the code layout
    always_comb begin
        o_code         = '0;
        o_code[POS_D1] = i_data[3];
        o_code[POS_D2] = i_data[2];
        o_code[POS_D3] = i_data[1];
        o_code[POS_D4] = i_data[0];
        o_code[POS_P1] = i_data[3] ^ i_data[2] ^ i_data[0];
        o_code[POS_P2] = i_data[3] ^ i_data[1] ^ i_data[0];
        o_code[POS_P3] = i_data[2] ^ i_data[1] ^ i_data[0];
    end

    // Parity checks; the resulting value names the flipped position
    always_comb begin
        o_syn    = '0;
        o_syn[0] = i_code[POS_P1] ^ i_code[POS_D1] ^ i_code[POS_D2] ^ i_code[POS_D4];
        o_syn[1] = i_code[POS_P2] ^ i_code[POS_D1] ^ i_code[POS_D3] ^ i_code[POS_D4];
        o_syn[2] = i_code[POS_P3] ^ i_code[POS_D2] ^ i_code[POS_D3] ^ i_code[POS_D4];
    end

endmodule : hamming74_core
`default_nettype wire

// File: rtl/hamming_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hamming_seq_ctrl
// Brief    : Start-button debounce plus the capture/encode/inject/decode/
//            correct sequencer; results are held for display until the next
//            debounced press.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_seq_ctrl
    import hamming_pkg::*;
#(
    parameter int DEB_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic [2:0] err_pos,
    input  logic       start,
    output logic [6:0] code_word,
    output logic [2:0] syndrome,
    output logic [3:0] corrected,
    output logic       err_flag,
    output logic       busy,
    output logic       done,
    output logic       disp_valid
);

    localparam int             CNT_W     = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_start_filt;
    logic             r_start_filt_d;
    logic             w_start_evt;

    state_t           r_state;
    logic [3:0]       r_data;
    logic [2:0]       r_pos;

    logic [6:0]       w_enc_code;
    logic [2:0]       w_syn;
    logic [6:0]       w_inj_mask;
    logic [6:0]       w_fix_mask;
    logic [6:0]       w_fixed;

    // Shared encoder/syndrome block: encodes the captured data and checks the held word
    hamming74_core u_core (
        .i_data (r_data),
        .i_code (code_word),
        .o_code (w_enc_code),
        .o_syn  (w_syn)
    );

    // Debounce: the filtered level follows start only after DEB_CYCLES straight disagreements
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_start_filt   <= 1'b0;
            r_start_filt_d <= 1'b0;
        end else begin
            r_start_filt_d <= r_start_filt;
            if (start != r_start_filt) begin
                if (r_cnt == c_cnt_max) begin
                    r_start_filt <= start;
                    r_cnt        <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign w_start_evt = r_start_filt & ~r_start_filt_d;

    // Single-bit masks for error injection (position 0 = none) and correction
    always_comb begin
        w_inj_mask = '0;
        w_fix_mask = '0;
        if (r_pos != 3'd0) begin
            w_inj_mask = 7'd1 << (r_pos - 3'd1);
        end
        if (syndrome != 3'd0) begin
            w_fix_mask = 7'd1 << (syndrome - 3'd1);
        end
    end

    assign w_fixed = code_word ^ w_fix_mask;

    // Sequencer with registered status outputs; each result updates only in its own state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_pos      <= '0;
            code_word  <= '0;
            syndrome   <= '0;
            corrected  <= '0;
            err_flag   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_evt) begin
                        r_state <= CAPTURE;
                        busy    <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_data  <= data_in;
                    r_pos   <= err_pos;
                    r_state <= ENCODE;
                end
                ENCODE: begin
                    code_word <= w_enc_code;
                    r_state   <= INJECT;
                end
                INJECT: begin
                    code_word <= code_word ^ w_inj_mask;
                    r_state   <= DECODE;
                end
                DECODE: begin
                    syndrome <= w_syn;
                    r_state  <= CORRECT;
                end
                CORRECT: begin
                    corrected  <= extract_data(w_fixed);
                    err_flag   <= (syndrome != 3'd0);
                    r_state    <= SHOW;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    disp_valid <= 1'b1;
                end
                SHOW: begin
                    if (w_start_evt) begin
                        r_state    <= CAPTURE;
                        busy       <= 1'b1;
                        disp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    busy       <= 1'b0;
                    disp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : hamming_seq_ctrl
`default_nettype wire

// File: tb/tb_hamming_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_seq_ctrl
// Brief    : Self-checking bench for hamming_seq_ctrl with a short debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_seq_ctrl;

    localparam int DEB = 4;
    // Ticks from raising start until done is seen: DEB filter edges, then 6 more
    localparam int LAT = DEB + 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data_in;
    logic [2:0] err_pos;
    logic       start;
    logic [6:0] code_word;
    logic [2:0] syndrome;
    logic [3:0] corrected;
    logic       err_flag;
    logic       busy;
    logic       done;
    logic       disp_valid;

    int checks = 0;
    int errors = 0;

    hamming_seq_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .err_pos    (err_pos),
        .start      (start),
        .code_word  (code_word),
        .syndrome   (syndrome),
        .corrected  (corrected),
        .err_flag   (err_flag),
        .busy       (busy),
        .done       (done),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    // Reference: build the code word by position number, parity p covers positions j with (j & p) != 0
    function automatic logic [6:0] m_code(input logic [3:0] d, input logic [2:0] p);
        logic c [1:7];
        logic [6:0] w;
        c[3] = d[3]; c[5] = d[2]; c[6] = d[1]; c[7] = d[0];
        c[1] = 1'b0; c[2] = 1'b0; c[4] = 1'b0;
        for (int k = 1; k <= 4; k = k * 2) begin
            logic par;
            par = 1'b0;
            for (int j = 3; j <= 7; j++)
                if (j != 4 && (j & k) != 0) par = par ^ c[j];
            c[k] = par;
        end
        if (p != 0) c[p] = ~c[p];
        for (int j = 1; j <= 7; j++) w[j-1] = c[j];
        return w;
    endfunction

    // Reference syndrome: XOR of the position numbers of all set bits
    function automatic logic [2:0] m_syn(input logic [6:0] w);
        int s;
        s = 0;
        for (int j = 1; j <= 7; j++)
            if (w[j-1]) s = s ^ j;
        return 3'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_start();
        start = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    // Raise start and wait (bounded) for done; n = ticks taken, 0 on timeout.
    // With scramble set, inputs are changed once the word has been captured.
    task automatic press_and_wait(input logic [3:0] d, input logic [2:0] p,
                                  input bit scramble, output int n);
        data_in = d;
        err_pos = p;
        start   = 1'b1;
        n       = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (scramble && i == DEB + 2) begin
                data_in = 4'($urandom);
                err_pos = 3'($urandom);
            end
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; data_in = '0; err_pos = '0;
        repeat (3) tick();
        checks++;
        if ({code_word, syndrome, corrected, err_flag, busy, done, disp_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {code_word, syndrome, corrected, err_flag, busy, done, disp_valid});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_known_vectors();
        logic [3:0] tv_d [3];
        logic [2:0] tv_p [3];
        logic [6:0] tv_c [3];
        logic [2:0] tv_s [3];
        logic [3:0] tv_o [3];
        int n;
        tv_d = '{4'b1011, 4'b1011, 4'b0000};
        tv_p = '{3'd0, 3'd5, 3'd1};
        tv_c = '{7'b1100110, 7'b1110110, 7'b0000001};
        tv_s = '{3'd0, 3'd5, 3'd1};
        tv_o = '{4'b1011, 4'b1011, 4'b0000};
        for (int v = 0; v < 3; v++) begin
            press_and_wait(tv_d[v], tv_p[v], 1'b0, n);
            checks++;
            if (n !== LAT) begin
                errors++;
                $display("FAIL known%0d_latency: got %0d ticks expected %0d", v, n, LAT);
            end
            checks++;
            if ({code_word, syndrome, corrected, err_flag} !== {tv_c[v], tv_s[v], tv_o[v], tv_p[v] != 0}) begin
                errors++;
                $display("FAIL known%0d_results: code %b syn %0d corr %b err %b expected code %b syn %0d corr %b err %b",
                         v, code_word, syndrome, corrected, err_flag,
                         tv_c[v], tv_s[v], tv_o[v], tv_p[v] != 0);
            end
            tick();
            checks++;
            if ({done, disp_valid, busy} !== 3'b010) begin
                errors++;
                $display("FAIL known%0d_show: done/disp_valid/busy %b expected 010", v, {done, disp_valid, busy});
            end
            release_start();
        end
    endtask

    task automatic test_reset_mid_traffic();
        data_in = 4'b0110; err_pos = 3'd2; start = 1'b1;
        repeat (DEB + 3) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({code_word, syndrome, corrected, err_flag, busy, done, disp_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_mid_traffic: got %b expected all zero",
                     {code_word, syndrome, corrected, err_flag, busy, done, disp_valid});
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (DEB + 4) tick();
        checks++;
        if ({busy, disp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_idle: busy/disp_valid %b expected 00", {busy, disp_valid});
        end
    endtask

    task automatic test_short_pulse();
        bit seen;
        seen = 1'b0;
        data_in = 4'b1111; err_pos = 3'd3;
        start = 1'b1;
        for (int i = 0; i < DEB - 1; i++) begin
            tick();
            seen = seen | busy | done | disp_valid;
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | busy | done | disp_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse: activity seen %b expected 0", seen);
        end
    endtask

    task automatic test_reset_in_decode_and_recapture();
        int n;
        logic [6:0] old_code;
        bit persist_ok;
        data_in = 4'b0110; err_pos = 3'd3; start = 1'b1;
        // CAPTURE is entered on tick DEB+1, so DECODE is current after tick DEB+4
        repeat (DEB + 4) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL decode_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0; start = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({code_word, syndrome, corrected, err_flag, busy, done, disp_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_in_decode: got %b expected all zero",
                     {code_word, syndrome, corrected, err_flag, busy, done, disp_valid});
        end
        repeat (2) tick();

        press_and_wait(4'b1001, 3'd7, 1'b0, n);
        checks++;
        if (n !== LAT || {code_word, syndrome, corrected, err_flag} !==
                         {m_code(4'b1001, 3'd7), 3'd7, 4'b1001, 1'b1}) begin
            errors++;
            $display("FAIL after_reset_press: ticks %0d code %b syn %0d corr %b err %b expected ticks %0d code %b syn 7 corr 1001 err 1",
                     n, code_word, syndrome, corrected, err_flag, LAT, m_code(4'b1001, 3'd7));
        end
        release_start();

        // Re-press from SHOW with new data; old results must persist while busy until overwritten
        old_code   = code_word;
        persist_ok = 1'b1;
        data_in = 4'b0101; err_pos = 3'd2; start = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == DEB + 1 && (code_word !== old_code || busy !== 1'b1 || disp_valid !== 1'b0))
                persist_ok = 1'b0;
            if (done) begin
                n = i;
                break;
            end
        end
        checks++;
        if (persist_ok !== 1'b1) begin
            errors++;
            $display("FAIL recapture_persist: old code %b not held with busy during CAPTURE", old_code);
        end
        checks++;
        if (n !== LAT || {code_word, syndrome, corrected, err_flag} !==
                         {m_code(4'b0101, 3'd2), 3'd2, 4'b0101, 1'b1}) begin
            errors++;
            $display("FAIL recapture_results: ticks %0d code %b syn %0d corr %b err %b expected code %b syn 2 corr 0101 err 1",
                     n, code_word, syndrome, corrected, err_flag, m_code(4'b0101, 3'd2));
        end
        release_start();
    endtask

    task automatic test_random();
        int n;
        logic [3:0] d;
        logic [2:0] p;
        logic [6:0] exp_c;
        for (int it = 0; it < 16; it++) begin
            d = 4'($urandom);
            p = 3'($urandom_range(0, 7));
            exp_c = m_code(d, p);
            press_and_wait(d, p, 1'b1, n);
            checks++;
            if (n !== LAT || {code_word, syndrome, corrected, err_flag} !==
                             {exp_c, m_syn(exp_c), d, m_syn(exp_c) != 0}) begin
                errors++;
                $display("FAIL random%0d d=%b p=%0d: ticks %0d code %b syn %0d corr %b err %b expected ticks %0d code %b syn %0d corr %b err %b",
                         it, d, p, n, code_word, syndrome, corrected, err_flag,
                         LAT, exp_c, m_syn(exp_c), d, m_syn(exp_c) != 0);
            end
            release_start();
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_reset_mid_traffic();
        test_short_pulse();
        test_reset_in_decode_and_recapture();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hamming_seq_ctrl
`default_nettype wire
